com_pulse_monitor: RTL and testbench
====================================

Name: com_pulse_monitor

Overview:
- Receive-side checker for periodic single-cycle strobes, such as the flag from the common cycle counter or any other periodic tick source.
- Measures the interval between strobes and compares it with the expected period and tolerance.
- Declares lock after a run of good intervals and drops lock on repeated bad intervals or a missing strobe.
- Used on testbed timing paths (frame/slot ticks) to flag timing faults to status registers.

Parameters:
- C_COUNT_NUM, 32'd100: expected interval in clock cycles; must be ≥1.
- C_TOL, 32'd0: allowed absolute deviation from C_COUNT_NUM, in cycles.
- C_LOCK_CNT, 8'd4: consecutive good intervals needed to enter LOCK; must be ≥1.
- C_LOSS_CNT, 8'd2: consecutive bad intervals in LOCK that drop back to ACQ; must be ≥1.
- C_TIMEOUT, 32'd200: cycles without a strobe that force IDLE; must be > C_COUNT_NUM + C_TOL.

Ports:
- I_clk, input, 1: clock. Single clock domain.
- I_rst, input, 1: reset. Synchronous and active-high.
- I_pulse, input, 1: strobe. Every cycle it is sampled high is one event.
- O_lock, output, 1: high while in LOCK.
- O_period, output, 32: last measured interval.
- O_periodVld, output, 1: one-cycle pulse when O_period updates.
- O_err, output, 1: one-cycle pulse on a bad interval or a timeout.
- O_timeout, output, 1: one-cycle pulse on a timeout.
- O_errCnt, output, 16: error count. Counts every O_err and saturates at 16'hFFFF.

Behaviour:
- Reset (sampled at I_clk):
  - state=IDLE; cnt=0; goodCnt=0; badCnt=0.
  - All outputs 0.
  - I_pulse is ignored while I_rst is high.
  - Reset asserted mid-operation clears everything on the next edge. The first pulse after reset is treated as the IDLE start event.
- Interval counter (32-bit cnt):
  - A pulse cycle sets cnt to 0.
  - Otherwise cnt increments (ACQ/LOCK only) and saturates at all-ones.
  - Measured period = cnt+1, computed at the pulse cycle. Pulses N cycles apart therefore measure N.
- Good interval: |period − C_COUNT_NUM| ≤ C_TOL, computed in 33-bit signed arithmetic with no wrap.
- Output timing:
  - All outputs are registered and change on the edge after the pulse/timeout cycle (latency 1).
  - O_period/O_periodVld update on every pulse in ACQ or LOCK, never on the IDLE pulse.
- State IDLE:
  - cnt is held at 0.
  - A pulse moves to ACQ with goodCnt=0 and badCnt=0.
- State ACQ:
  - Good pulse: goodCnt++. If goodCnt+1 == C_LOCK_CNT, go to LOCK with badCnt=0 and O_lock=1.
  - Bad pulse: goodCnt=0, O_err pulse, errCnt++. Stay in ACQ.
- State LOCK:
  - Good pulse: badCnt=0.
  - Bad pulse: badCnt++, O_err pulse, errCnt++. If badCnt+1 == C_LOSS_CNT, go to ACQ with goodCnt=0 and O_lock=0.
- Timeout (ACQ or LOCK):
  - Condition: no pulse this cycle and cnt+1 == C_TIMEOUT.
  - Action: go to IDLE, O_lock=0, O_timeout and O_err pulse, errCnt++.
  - No O_periodVld is produced.
- Simultaneous events:
  - A pulse on the cycle cnt+1 == C_TIMEOUT is a normal measurement (period = C_TIMEOUT, which is bad), not a timeout.
  - Back-to-back high cycles are separate events, each with period 1.
- errCnt saturates and never wraps. Only I_rst clears it.
- C_LOCK_CNT=1: the first good interval locks. C_LOSS_CNT=1: the first bad interval in LOCK unlocks.

Test Plan:
- Lock acquisition (defaults):
  - Stimulus: pulses at cycles 10, 110, 210, 310, 410.
  - Response: O_periodVld at 111/211/311/411 with O_period=100. O_lock rises at 411. O_err stays 0 and errCnt=0.
- Single glitch in LOCK (C_TOL=1):
  - Stimulus: after lock, intervals 101, 99, then 103.
  - Response: no error for 101/99. For 103: O_period=103, one O_err, errCnt=1, O_lock stays 1.
  - A following good interval resets badCnt.
- Loss of lock:
  - Stimulus: after lock, two consecutive intervals of 90.
  - Response: O_err twice, errCnt=2, O_lock falls the cycle after the second bad pulse.
  - Then 4 good intervals relock.
- Timeout:
  - Stimulus: after lock, stop pulses after last pulse at T.
  - Response: at T+201, O_timeout=1, O_err=1, O_lock=0 (all one cycle), errCnt+1.
  - Next pulse produces no O_periodVld (IDLE start). The following interval of 100 gives O_period=100.
- Boundary:
  - Stimulus: pulse exactly at cnt+1=200.
  - Response: O_period=200 with O_err, no O_timeout.
  - Stimulus: I_pulse held high 3 cycles.
  - Response: periods of 1, each flagged bad.
- Reset and saturation:
  - Stimulus: assert I_rst for 1 cycle while locked.
  - Response: all outputs 0 next cycle, and a pulse during reset is ignored.
  - Stimulus: force 65540 bad intervals (C_COUNT_NUM=4, pulses every 2).
  - Response: errCnt holds 16'hFFFF.

Source files
------------

// File: rtl/com_pulse_monitor_if.sv
// Strobe input and status outputs of the pulse monitor.
interface com_pulse_monitor_if;
   logic        I_pulse;
   logic        O_lock;
   logic [31:0] O_period;
   logic        O_periodVld;
   logic        O_err;
   logic        O_timeout;
   logic [15:0] O_errCnt;

   // Tick source / status consumer side
   modport master (
      output I_pulse,
      input  O_lock, O_period, O_periodVld, O_err, O_timeout, O_errCnt
   );

   // Monitor side
   modport slave (
      input  I_pulse,
      output O_lock, O_period, O_periodVld, O_err, O_timeout, O_errCnt
   );
endinterface

// File: rtl/com_pulse_monitor.sv
// Periodic strobe checker: measures strobe intervals, tracks lock, flags
// bad intervals and missing strobes.
module com_pulse_monitor #(
   parameter logic [31:0] C_COUNT_NUM = 32'd100,
   parameter logic [31:0] C_TOL       = 32'd0,
   parameter logic [7:0]  C_LOCK_CNT  = 8'd4,
   parameter logic [7:0]  C_LOSS_CNT  = 8'd2,
   parameter logic [31:0] C_TIMEOUT   = 32'd200
) (
   input  logic               I_clk,
   input  logic               I_rst,
   com_pulse_monitor_if.slave mon
);
   localparam int unsigned CNT_W = 32;
   localparam int unsigned RUN_W = 8;
   localparam int unsigned ERR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [RUN_W-1:0]   good_cnt;
   logic [RUN_W-1:0]   bad_cnt;
   logic               lock_q;
   logic [CNT_W-1:0]   period_q;
   logic               period_vld_q;
   logic               err_q;
   logic               timeout_q;
   logic [ERR_W-1:0]   err_cnt_q;

   logic [CNT_W-1:0]   period_c;
   logic signed [CNT_W:0] diff_c;
   logic [CNT_W:0]     abs_c;
   logic               good_c;
   logic               timeout_hit_c;
   logic [ERR_W-1:0]   err_cnt_inc_c;
   logic [RUN_W-1:0]   good_nxt_c;
   logic [RUN_W-1:0]   bad_nxt_c;

   // Interval measurement and tolerance check in 33-bit signed arithmetic
   assign period_c      = cnt + CNT_W'(1);
   assign diff_c        = $signed({1'b0, period_c}) - $signed({1'b0, C_COUNT_NUM});
   assign abs_c         = diff_c[CNT_W] ? (CNT_W+1)'(-diff_c) : (CNT_W+1)'(diff_c);
   assign good_c        = (abs_c <= {1'b0, C_TOL});
   assign timeout_hit_c = (period_c == C_TIMEOUT);
   assign err_cnt_inc_c = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
   assign good_nxt_c    = good_cnt + RUN_W'(1);
   assign bad_nxt_c     = bad_cnt + RUN_W'(1);

   // Lock FSM, interval counter and registered status outputs
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
         lock_q       <= 1'b0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         period_vld_q <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (mon.I_pulse) begin
                  state    <= ST_ACQ;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
               end
            end
            ST_ACQ, ST_LOCK: begin
               if (mon.I_pulse) begin
                  cnt          <= '0;
                  period_q     <= period_c;
                  period_vld_q <= 1'b1;
                  if (good_c) begin
                     if (state == ST_ACQ) begin
                        good_cnt <= good_nxt_c;
                        if (good_nxt_c == C_LOCK_CNT) begin
                           state   <= ST_LOCK;
                           bad_cnt <= '0;
                           lock_q  <= 1'b1;
                        end
                     end else begin
                        bad_cnt <= '0;
                     end
                  end else begin
                     err_q     <= 1'b1;
                     err_cnt_q <= err_cnt_inc_c;
                     if (state == ST_ACQ) begin
                        good_cnt <= '0;
                     end else begin
                        bad_cnt <= bad_nxt_c;
                        if (bad_nxt_c == C_LOSS_CNT) begin
                           state    <= ST_ACQ;
                           good_cnt <= '0;
                           lock_q   <= 1'b0;
                        end
                     end
                  end
               end else if (timeout_hit_c) begin
                  // Missing strobe: drop straight back to waiting for a start event
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  lock_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  err_q     <= 1'b1;
                  err_cnt_q <= err_cnt_inc_c;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mon.O_lock      = lock_q;
   assign mon.O_period    = period_q;
   assign mon.O_periodVld = period_vld_q;
   assign mon.O_err       = err_q;
   assign mon.O_timeout   = timeout_q;
   assign mon.O_errCnt    = err_cnt_q;

endmodule

// File: tb/tb_com_pulse_monitor.sv
// Directed bench for com_pulse_monitor (C_TOL=1, other parameters default).
module tb_com_pulse_monitor;
   logic I_clk;
   logic I_rst;
   int   checks;
   int   errors;
   int   since;

   com_pulse_monitor_if bus ();

   com_pulse_monitor #(
      .C_COUNT_NUM (32'd100),
      .C_TOL       (32'd1),
      .C_LOCK_CNT  (8'd4),
      .C_LOSS_CNT  (8'd2),
      .C_TIMEOUT   (32'd200)
   ) dut (
      .I_clk (I_clk),
      .I_rst (I_rst),
      .mon   (bus.slave)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   // Compare one observed value with its expected value
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge
   task automatic tick();
      @(posedge I_clk);
      #1;
      if (bus.I_pulse) since = 0;
      else since++;
   endtask

   // Issue one strobe exactly gap cycles after the previous one
   task automatic send(input int gap);
      bus.I_pulse = 1'b0;
      while (since < gap - 1) tick();
      bus.I_pulse = 1'b1;
      tick();
      bus.I_pulse = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      since       = 0;
      I_rst       = 1'b1;
      bus.I_pulse = 1'b0;
      tick();
      tick();
      chk("rst_lock",    32'(bus.O_lock),      32'd0);
      chk("rst_period",  bus.O_period,         32'd0);
      chk("rst_vld",     32'(bus.O_periodVld), 32'd0);
      chk("rst_err",     32'(bus.O_err),       32'd0);
      chk("rst_timeout", 32'(bus.O_timeout),   32'd0);
      chk("rst_errcnt",  32'(bus.O_errCnt),    32'd0);
      I_rst = 1'b0;

      // Lock acquisition
      send(10);
      chk("idle_start_vld", 32'(bus.O_periodVld), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         send(100);
         chk("acq_vld",    32'(bus.O_periodVld), 32'd1);
         chk("acq_period", bus.O_period,         32'd100);
         chk("acq_err",    32'(bus.O_err),       32'd0);
         chk("acq_lock",   32'(bus.O_lock),      (i == 4) ? 32'd1 : 32'd0);
      end
      chk("acq_errcnt", 32'(bus.O_errCnt), 32'd0);
      tick();
      chk("vld_one_cycle", 32'(bus.O_periodVld), 32'd0);

      // Glitches within tolerance, then one out of tolerance
      send(101);
      chk("tol101_err",    32'(bus.O_err),  32'd0);
      chk("tol101_period", bus.O_period,    32'd101);
      send(99);
      chk("tol99_err",     32'(bus.O_err),  32'd0);
      send(103);
      chk("bad103_period", bus.O_period,        32'd103);
      chk("bad103_err",    32'(bus.O_err),      32'd1);
      chk("bad103_errcnt", 32'(bus.O_errCnt),   32'd1);
      chk("bad103_lock",   32'(bus.O_lock),     32'd1);
      tick();
      chk("err_one_cycle", 32'(bus.O_err), 32'd0);
      send(100);
      send(90);
      chk("badcnt_cleared_lock", 32'(bus.O_lock),   32'd1);
      chk("badcnt_cleared_cnt",  32'(bus.O_errCnt), 32'd2);
      send(100);

      // Loss of lock on two consecutive bad intervals
      send(90);
      chk("loss1_err",  32'(bus.O_err),    32'd1);
      chk("loss1_lock", 32'(bus.O_lock),   32'd1);
      send(90);
      chk("loss2_err",    32'(bus.O_err),    32'd1);
      chk("loss2_errcnt", 32'(bus.O_errCnt), 32'd4);
      chk("loss2_lock",   32'(bus.O_lock),   32'd0);
      for (int i = 1; i <= 4; i++) begin
         send(100);
         chk("relock_lock", 32'(bus.O_lock), (i == 4) ? 32'd1 : 32'd0);
      end

      // Timeout after the last strobe
      repeat (199) tick();
      chk("pre_timeout", 32'(bus.O_timeout), 32'd0);
      chk("pre_timeout_lock", 32'(bus.O_lock), 32'd1);
      tick();
      chk("timeout",        32'(bus.O_timeout),   32'd1);
      chk("timeout_err",    32'(bus.O_err),       32'd1);
      chk("timeout_lock",   32'(bus.O_lock),      32'd0);
      chk("timeout_vld",    32'(bus.O_periodVld), 32'd0);
      chk("timeout_errcnt", 32'(bus.O_errCnt),    32'd5);
      tick();
      chk("timeout_one_cycle", 32'(bus.O_timeout), 32'd0);
      send(50);
      chk("post_to_idle_vld", 32'(bus.O_periodVld), 32'd0);
      send(100);
      chk("post_to_vld",    32'(bus.O_periodVld), 32'd1);
      chk("post_to_period", bus.O_period,         32'd100);
      chk("post_to_err",    32'(bus.O_err),       32'd0);

      // Strobe exactly on the timeout cycle is a measurement
      send(200);
      chk("b200_period",  bus.O_period,       32'd200);
      chk("b200_err",     32'(bus.O_err),     32'd1);
      chk("b200_timeout", 32'(bus.O_timeout), 32'd0);
      chk("b200_errcnt",  32'(bus.O_errCnt),  32'd6);

      // Back-to-back strobes, each a period of 1
      bus.I_pulse = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b2b_vld",    32'(bus.O_periodVld), 32'd1);
         chk("b2b_period", bus.O_period,         32'd1);
         chk("b2b_err",    32'(bus.O_err),       32'd1);
         chk("b2b_errcnt", 32'(bus.O_errCnt),    32'(7 + i));
      end
      bus.I_pulse = 1'b0;

      // Reset while locked, with a strobe during reset
      for (int i = 0; i < 4; i++) send(100);
      chk("prerst_lock", 32'(bus.O_lock), 32'd1);
      I_rst = 1'b1;
      bus.I_pulse = 1'b1;
      tick();
      chk("midrst_lock",   32'(bus.O_lock),      32'd0);
      chk("midrst_period", bus.O_period,         32'd0);
      chk("midrst_vld",    32'(bus.O_periodVld), 32'd0);
      chk("midrst_err",    32'(bus.O_err),       32'd0);
      chk("midrst_errcnt", 32'(bus.O_errCnt),    32'd0);
      I_rst = 1'b0;
      bus.I_pulse = 1'b0;
      tick();
      send(37);
      chk("rst_pulse_ignored_vld", 32'(bus.O_periodVld), 32'd0);
      send(100);
      chk("after_rst_vld",    32'(bus.O_periodVld), 32'd1);
      chk("after_rst_period", bus.O_period,         32'd100);

      // Error counter saturation
      bus.I_pulse = 1'b1;
      repeat (65534) tick();
      chk("sat_fffe", 32'(bus.O_errCnt), 32'h0000_FFFE);
      tick();
      chk("sat_ffff", 32'(bus.O_errCnt), 32'h0000_FFFF);
      repeat (5) tick();
      chk("sat_hold",     32'(bus.O_errCnt), 32'h0000_FFFF);
      chk("sat_hold_err", 32'(bus.O_err),    32'd1);
      bus.I_pulse = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
